// File: rtl/trap_pkg.sv
// trap_pkg: shared constants for the machine-mode trap controller.
// Holds FSM state codes, cause codes, CSR addresses and mstatus bit positions.
package trap_pkg;

  localparam int unsigned XLEN = 32;

  // Sequencer states
  typedef logic [1:0] state_t;
  localparam state_t StIdle     = 2'd0;
  localparam state_t StFlush    = 2'd1;
  localparam state_t StRedirect = 2'd2;

  // Exception cause codes
  localparam logic [3:0] CodeIllegal          = 4'd2;
  localparam logic [3:0] CodeInstrMisaligned  = 4'd0;
  localparam logic [3:0] CodeEcall            = 4'd11;
  localparam logic [3:0] CodeStoreMisaligned  = 4'd6;
  localparam logic [3:0] CodeLoadMisaligned   = 4'd4;

  // Interrupt cause codes (also their bit positions in mie/mip)
  localparam logic [3:0] CodeIrqSoftware = 4'd3;
  localparam logic [3:0] CodeIrqTimer    = 4'd7;
  localparam logic [3:0] CodeIrqExternal = 4'd11;

  // CSR addresses
  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMie     = 12'h304;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMip     = 12'h344;

  // mstatus bit positions
  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;

  // Only the three machine interrupt enables are implemented
  localparam logic [XLEN-1:0] MieWriteMask = 32'h0000_0888;

  // Trap target: BASE, or BASE + 4*code for interrupts when mtvec.MODE=1.
  // MODE bit 0 is held at zero when vectoring is not built in.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                   input logic            is_irq,
                                                   input logic [3:0]      code);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[0] && is_irq) begin
      return base + {{(XLEN-6){1'b0}}, code, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_cause_encoder.sv
// trap_cause_encoder: fixed-priority selection of the trap cause.
// Any exception beats any interrupt; interrupt inputs are already masked.
module trap_cause_encoder
  import trap_pkg::*;
(
  input  logic       exc_illegal_i,
  input  logic       exc_instr_misaligned_i,
  input  logic       exc_ecall_i,
  input  logic       exc_store_misaligned_i,
  input  logic       exc_load_misaligned_i,
  input  logic       irq_software_i,
  input  logic       irq_timer_i,
  input  logic       irq_external_i,
  output logic       valid_o,
  output logic       is_interrupt_o,
  output logic [3:0] code_o
);

  // Priority chain: exceptions first, then external > software > timer
  always_comb begin
    valid_o        = 1'b1;
    is_interrupt_o = 1'b0;
    code_o         = 4'd0;
    if (exc_illegal_i) begin
      code_o = CodeIllegal;
    end else if (exc_instr_misaligned_i) begin
      code_o = CodeInstrMisaligned;
    end else if (exc_ecall_i) begin
      code_o = CodeEcall;
    end else if (exc_store_misaligned_i) begin
      code_o = CodeStoreMisaligned;
    end else if (exc_load_misaligned_i) begin
      code_o = CodeLoadMisaligned;
    end else if (irq_external_i) begin
      is_interrupt_o = 1'b1;
      code_o         = CodeIrqExternal;
    end else if (irq_software_i) begin
      is_interrupt_o = 1'b1;
      code_o         = CodeIrqSoftware;
    end else if (irq_timer_i) begin
      is_interrupt_o = 1'b1;
      code_o         = CodeIrqTimer;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer.
// Owns mstatus.MIE/MPIE, mie, mtvec, mepc, mcause; runs IDLE -> FLUSH -> REDIRECT
// on trap entry or mret. Define VECTORED_INTERRUPT_EN to make mtvec.MODE writable
// (0/1) so interrupts vector to BASE + 4*code; otherwise MODE reads 0.
module trap_controller
  import trap_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  input  logic            mem_stall_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            exc_illegal_i,
  input  logic            exc_instr_misaligned_i,
  input  logic            exc_ecall_i,
  input  logic            exc_store_misaligned_i,
  input  logic            exc_load_misaligned_i,
  input  logic            irq_software_i,
  input  logic            irq_timer_i,
  input  logic            irq_external_i,
  input  logic            mret_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i
);

  state_t          state_q, state_d;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            is_idle, recognize, take_trap, take_mret, seq_take, csr_wr;
  logic            cause_valid, cause_is_irq;
  logic [3:0]      cause_code;
  logic [XLEN-1:0] mip, mtvec_wdata;

  assign is_idle   = (state_q == StIdle);
  assign recognize = is_idle & instr_valid_i & ~mem_stall_i;
  assign take_trap = recognize & cause_valid;
  // A trap in the same cycle suppresses mret
  assign take_mret = recognize & mret_i & ~cause_valid;
  assign seq_take  = take_trap | take_mret;
  assign csr_wr    = is_idle & csr_we_i;

  assign mip = {20'b0, irq_external_i, 3'b0, irq_timer_i, 3'b0, irq_software_i, 3'b0};

`ifdef VECTORED_INTERRUPT_EN
  assign mtvec_wdata = {csr_wdata_i[XLEN-1:2], 1'b0, csr_wdata_i[0]};
`else
  assign mtvec_wdata = {csr_wdata_i[XLEN-1:2], 2'b00};
`endif

  trap_cause_encoder u_cause (
    .exc_illegal_i          (exc_illegal_i),
    .exc_instr_misaligned_i (exc_instr_misaligned_i),
    .exc_ecall_i            (exc_ecall_i),
    .exc_store_misaligned_i (exc_store_misaligned_i),
    .exc_load_misaligned_i  (exc_load_misaligned_i),
    .irq_software_i         (mstatus_mie_q & mie_q[CodeIrqSoftware] & irq_software_i),
    .irq_timer_i            (mstatus_mie_q & mie_q[CodeIrqTimer] & irq_timer_i),
    .irq_external_i         (mstatus_mie_q & mie_q[CodeIrqExternal] & irq_external_i),
    .valid_o                (cause_valid),
    .is_interrupt_o         (cause_is_irq),
    .code_o                 (cause_code)
  );

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (seq_take) state_d = StFlush;
      StFlush:    state_d = StRedirect;
      StRedirect: if (redirect_ready_i) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // CSR next state: software writes first, trap/mret updates override them
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    target_d       = target_q;

    if (csr_wr) begin
      case (csr_addr_i)
        CsrMstatus: begin
          if (!seq_take) begin
            mstatus_mie_d  = csr_wdata_i[MstatusMieBit];
            mstatus_mpie_d = csr_wdata_i[MstatusMpieBit];
          end
        end
        CsrMie:    mie_d   = csr_wdata_i & MieWriteMask;
        CsrMtvec:  mtvec_d = mtvec_wdata;
        CsrMepc:   if (!seq_take) mepc_d = {csr_wdata_i[XLEN-1:2], 2'b00};
        CsrMcause: if (!seq_take) mcause_d = csr_wdata_i;
        default:   ;
      endcase
    end

    if (take_trap) begin
      mepc_d         = {trap_pc_i[XLEN-1:2], 2'b00};
      mcause_d       = {cause_is_irq, {(XLEN-5){1'b0}}, cause_code};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      target_d       = trap_target(mtvec_q, cause_is_irq, cause_code);
    end else if (take_mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      target_d       = mepc_q;
    end
  end

  // State and CSR registers, synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q        <= StIdle;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      target_q       <= '0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      target_q       <= target_d;
    end
  end

  // Combinational CSR read; unmapped addresses read zero
  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      CsrMstatus: begin
        csr_rdata_o[MstatusMieBit]  = mstatus_mie_q;
        csr_rdata_o[MstatusMpieBit] = mstatus_mpie_q;
      end
      CsrMie:    csr_rdata_o = mie_q;
      CsrMtvec:  csr_rdata_o = mtvec_q;
      CsrMepc:   csr_rdata_o = mepc_q;
      CsrMcause: csr_rdata_o = mcause_q;
      CsrMip:    csr_rdata_o = mip;
      default:   csr_rdata_o = '0;
    endcase
  end

  assign flush_o          = (state_q == StFlush);
  assign stall_o          = ~is_idle;
  assign redirect_valid_o = (state_q == StRedirect);
  assign redirect_pc_o    = target_q;

endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap sequencer for the core. Samples memory-stage exceptions and the three machine interrupts, owns mstatus.MIE/MPIE, mie, mtvec, mepc and mcause, and runs a flush/redirect sequence on trap entry and on mret. Its flush and stall outputs feed the pipeline controller; its redirect feeds fetch.

## Interface
- XLEN, 32, datapath/CSR width
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- instr_valid_i  in  1  memory stage holds a valid instruction
- mem_stall_i  in  1  memory stage stalled; traps and mret not recognised while high
- trap_pc_i  in  XLEN  PC of memory-stage instruction
- exc_illegal_i, exc_instr_misaligned_i, exc_ecall_i, exc_store_misaligned_i, exc_load_misaligned_i  in  1 each  exception flags
- irq_software_i, irq_timer_i, irq_external_i  in  1 each  level-sensitive pending lines
- mret_i  in  1  memory-stage instruction is mret
- csr_we_i  in  1  CSR write strobe; csr_addr_i  in  12; csr_wdata_i  in  XLEN
- csr_rdata_o  out  XLEN  combinational read of csr_addr_i
- flush_o  out  1  flush all stages
- stall_o  out  1  hold fetch while sequencing
- redirect_valid_o  out  1; redirect_pc_o  out  XLEN; redirect_ready_i  in  1  fetch accepts redirect

## Operation
- States: IDLE, FLUSH, REDIRECT.
- Recognition happens in IDLE only, when instr_valid_i=1 and mem_stall_i=0.
- Exception priority: illegal (2) > instr misaligned (0) > ecall (11) > store misaligned (6) > load misaligned (4).
- An interrupt is enabled when mstatus.MIE=1 and its mie bit=1.
- Interrupt priority: external (11) > software (3) > timer (7).
- Any exception beats any interrupt. A trap beats mret in the same cycle.
- Trap entry (end of recognition cycle):
  - mepc <= trap_pc_i with bits[1:0]=0.
  - mcause <= {interrupt, 27'b0, code}.
  - MPIE <= MIE; MIE <= 0.
  - State goes to FLUSH.
- Trap target: mtvec.BASE, or BASE+4*code for interrupts in vectored mode.
- mret: MIE <= MPIE, MPIE <= 1; state goes to FLUSH; target is mepc.
- FLUSH: flush_o=1 and stall_o=1 for exactly one cycle, then REDIRECT.
- REDIRECT:
  - redirect_valid_o=1 and stall_o=1; redirect_pc_o holds the target stable.
  - Leaves for IDLE on the cycle after redirect_valid_o & redirect_ready_i.
- CSR map: mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), mie 0x304 (bits 3/7/11), mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344 (read-only, live irq lines).
- Unmapped addresses read 0; writes to them are dropped.
- CSR writes are ignored outside IDLE.
- CSR write in the same cycle as trap/mret recognition: the trap/mret update wins for mstatus, mepc and mcause; writes to mie and mtvec still apply.
- mepc writes force bits[1:0]=0.

## Timing
- Reset: state IDLE; all CSRs 0; flush_o, stall_o, redirect_valid_o = 0; redirect_pc_o = 0.
- Recognition at cycle T; updated CSRs visible in csr_rdata_o at T+1.
- flush_o asserted at T+1; redirect_valid_o from T+2.
- Minimum trap-to-IDLE is 3 cycles, reached when redirect_ready_i is high at T+2.
- Inputs sampled outside IDLE are ignored. There is no queueing: a level interrupt still pending re-triggers after return to IDLE.
- Reset asserted mid-sequence returns to IDLE on the next edge; no redirect is issued.

## Configuration
- VECTORED_INTERRUPT_EN defined: mtvec.MODE is WARL {0,1}. MODE=1 vectors interrupts to BASE+4*code; exceptions still go to BASE.
- Undefined: MODE is hardwired 0 and reads 0; all traps go to BASE.

## Structure
- trap_pkg holds:
  - state enum
  - cause codes
  - CSR addresses
  - mstatus bit positions
- Sub-module trap_cause_encoder (combinational), outputs {valid, is_interrupt, code[3:0]}, from:
  - the five exception flags
  - the masked interrupts

## Test plan
- ecall at trap_pc_i=0x100, mtvec=0x800:
  - mcause=0x0000000B, mepc=0x100
  - flush_o pulses at T+1; redirect to 0x800 at T+2.
- illegal and load-misaligned in the same cycle -> mcause=2.
- MIE=1, mie=0x888, all three irqs high:
  - mcause=0x8000000B, MIE=0, MPIE=1.
  - With VECTORED_INTERRUPT_EN and mtvec=0x801: redirect 0x82C.
- mret with mepc=0x204, MPIE=1 -> redirect 0x204, MIE=1, MPIE=1.
- redirect_ready_i held low 4 cycles:
  - redirect_valid_o and pc stable throughout.
  - IDLE one cycle after ready.
  - An exception during the wait is ignored.
- Reset asserted while in FLUSH -> next cycle IDLE, all outputs 0, CSRs 0.
